// File: rtl/tube_p_blkxfer_if.sv
// -----------------------------------------------------------------------------
// tube_p_blkxfer_if
//   Bus bundle between the block-transfer engine and its two neighbours:
//   the Tube ULA parasite port and a parasite-side memory port.
//
//   Tube side : t_nmi_b (async NMI from the ULA), t_cs_b, t_addr, t_rdnw,
//               t_wdata (to ULA p_data_in), t_rdata (from ULA p_data_out),
//               t_own (engine has the parasite port muxed to itself)
//   Memory    : m_req/m_ack handshake, m_we, m_addr, m_wdata, m_rdata
//
//   master : the engine (drives selects, addresses, write data, requests)
//   slave  : the Tube ULA + memory side (drives NMI, read data, ack)
// -----------------------------------------------------------------------------
interface tube_p_blkxfer_if;
  // Tube parasite port
  logic        t_nmi_b;
  logic        t_cs_b;
  logic [2:0]  t_addr;
  logic        t_rdnw;
  logic [7:0]  t_wdata;
  logic [7:0]  t_rdata;
  logic        t_own;

  // Parasite memory port
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic        m_ack;

  modport master (
    input  t_nmi_b,
    input  t_rdata,
    input  m_rdata,
    input  m_ack,
    output t_cs_b,
    output t_addr,
    output t_rdnw,
    output t_wdata,
    output t_own,
    output m_req,
    output m_we,
    output m_addr,
    output m_wdata
  );

  modport slave (
    output t_nmi_b,
    output t_rdata,
    output m_rdata,
    output m_ack,
    input  t_cs_b,
    input  t_addr,
    input  t_rdnw,
    input  t_wdata,
    input  t_own,
    input  m_req,
    input  m_we,
    input  m_addr,
    input  m_wdata
  );
endinterface

// File: rtl/tube_p_blkxfer.sv
// -----------------------------------------------------------------------------
// tube_p_blkxfer
//   Parasite-side NMI-driven block-transfer engine. Sits downstream of the
//   Tube ULA parasite port and services Tube register 3 (address 5) whenever
//   the ULA raises PNMI, instead of the coprocessor's own NMI handler.
//
//   dir=0 : Tube register 3 -> memory   (TUBE_RD, MEM_WR, RECOVER per byte)
//   dir=1 : memory -> Tube register 3   (MEM_RD, TUBE_WR, RECOVER per byte)
//   Each NMI moves 1 byte, or 2 when two_byte is set (matches the Tube V flag).
//
//   Ports
//     p_phi2, h_rst_b       : parasite clock, async active-low reset
//     start                 : one-cycle pulse, latches the config when idle
//     abort                 : level; honoured only between bus cycles
//     dir, two_byte         : transfer direction / bytes per NMI
//     base_addr, length     : first memory address / byte count (0 = none)
//     bus (master)          : Tube parasite port + memory req/ack port
//     busy, done, remaining : status; done pulses once at completion/abort
//
//   Parameter
//     NMI_HOLDOFF : cycles after a Tube access before the synchronised NMI is
//                   trusted again (2-flop sync latency + ULA FIFO flag update)
// -----------------------------------------------------------------------------
module tube_p_blkxfer #(
  parameter int NMI_HOLDOFF = 3
) (
  input  logic                    p_phi2,
  input  logic                    h_rst_b,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    dir,
  input  logic                    two_byte,
  input  logic [15:0]             base_addr,
  input  logic [15:0]             length,
  tube_p_blkxfer_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             remaining
);

  // Tube register 3 lives at parasite address 5.
  localparam logic [2:0] TUBE_REG3 = 3'd5;

  localparam int HOLD_W = (NMI_HOLDOFF < 2) ? 1 : $clog2(NMI_HOLDOFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(NMI_HOLDOFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TUBE_RD,
    S_MEM_WR,
    S_MEM_RD,
    S_TUBE_WR,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t            state_reg,     state_next;
  logic              dir_reg,       dir_next;
  logic              two_byte_reg,  two_byte_next;
  logic [15:0]       m_addr_reg,    m_addr_next;
  logic [15:0]       remaining_reg, remaining_next;
  logic [1:0]        burst_reg,     burst_next;
  logic [HOLD_W-1:0] holdoff_reg,   holdoff_next;
  logic [7:0]        t_wdata_reg,   t_wdata_next;
  logic [7:0]        m_wdata_reg,   m_wdata_next;

  // Two-flop synchroniser for the ULA's asynchronous NMI; idles high.
  logic [1:0]        nmi_sync_reg;
  logic              nmi_s;

  assign nmi_s = nmi_sync_reg[1];

  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      nmi_sync_reg <= 2'b11;
    end else begin
      nmi_sync_reg <= {nmi_sync_reg[0], bus.t_nmi_b};
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_reg     <= S_IDLE;
      dir_reg       <= 1'b0;
      two_byte_reg  <= 1'b0;
      m_addr_reg    <= 16'h0000;
      remaining_reg <= 16'h0000;
      burst_reg     <= 2'd0;
      holdoff_reg   <= '0;
      t_wdata_reg   <= 8'h00;
      m_wdata_reg   <= 8'h00;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      two_byte_reg  <= two_byte_next;
      m_addr_reg    <= m_addr_next;
      remaining_reg <= remaining_next;
      burst_reg     <= burst_next;
      holdoff_reg   <= holdoff_next;
      t_wdata_reg   <= t_wdata_next;
      m_wdata_reg   <= m_wdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    dir_next       = dir_reg;
    two_byte_next  = two_byte_reg;
    m_addr_next    = m_addr_reg;
    remaining_next = remaining_reg;
    burst_next     = burst_reg;
    t_wdata_next   = t_wdata_reg;
    m_wdata_next   = m_wdata_reg;
    // Holdoff counts down everywhere; RECOVER overrides with a reload.
    holdoff_next   = (holdoff_reg != '0) ? holdoff_reg - 1'b1 : '0;

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          dir_next       = dir;
          two_byte_next  = two_byte;
          m_addr_next    = base_addr;
          remaining_next = length;
          // A zero-length request completes without touching either bus.
          state_next     = (length == 16'h0000) ? S_DONE : S_ARM;
        end
      end

      S_ARM: begin
        if (abort) begin
          state_next = S_DONE;
        end else if (holdoff_reg == '0 && !nmi_s) begin
          // Burst size is bytes-per-NMI, clipped to what is left.
          burst_next = (two_byte_reg && remaining_reg >= 16'd2) ? 2'd2 : 2'd1;
          state_next = dir_reg ? S_MEM_RD : S_TUBE_RD;
        end
      end

      S_TUBE_RD: begin
        m_wdata_next = bus.t_rdata;
        state_next   = S_MEM_WR;
      end

      S_MEM_WR: begin
        // Ack is honoured in the very first cycle of the request.
        if (bus.m_ack) begin
          m_addr_next    = m_addr_reg + 16'd1;
          remaining_next = remaining_reg - 16'd1;
          burst_next     = burst_reg - 2'd1;
          state_next     = S_RECOVER;
        end
      end

      S_MEM_RD: begin
        if (bus.m_ack) begin
          t_wdata_next = bus.m_rdata;
          state_next   = S_TUBE_WR;
        end
      end

      S_TUBE_WR: begin
        m_addr_next    = m_addr_reg + 16'd1;
        remaining_next = remaining_reg - 16'd1;
        burst_next     = burst_reg - 2'd1;
        state_next     = S_RECOVER;
      end

      S_RECOVER: begin
        // Deselect cycle after every Tube access; the NMI we see next is
        // stale until the sync chain and FIFO flags have caught up.
        holdoff_next = HOLD_LOAD;
        if (remaining_reg == 16'h0000 || abort) begin
          state_next = S_DONE;
        end else if (burst_reg != 2'd0) begin
          // Second byte of a V-flag burst: the NMI already covered it.
          state_next = dir_reg ? S_MEM_RD : S_TUBE_RD;
        end else begin
          state_next = S_ARM;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the registered state so each Tube access is exactly
  // one clean cycle and nothing glitches off the datapath.
  // ---------------------------------------------------------------------------
  logic tube_access;
  logic mem_access;

  assign tube_access = (state_reg == S_TUBE_RD) || (state_reg == S_TUBE_WR);
  assign mem_access  = (state_reg == S_MEM_RD)  || (state_reg == S_MEM_WR);

  assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done      = (state_reg == S_DONE);
  assign remaining = remaining_reg;

  assign bus.t_cs_b  = ~tube_access;
  assign bus.t_addr  = TUBE_REG3;
  assign bus.t_rdnw  = (state_reg != S_TUBE_WR);
  assign bus.t_wdata = t_wdata_reg;
  assign bus.t_own   = busy;

  assign bus.m_req   = mem_access;
  assign bus.m_we    = (state_reg == S_MEM_WR);
  assign bus.m_addr  = m_addr_reg;
  assign bus.m_wdata = m_wdata_reg;

endmodule

// File: tb/tb_tube_p_blkxfer.sv
// -----------------------------------------------------------------------------
// tb_tube_p_blkxfer
//   Self-checking bench for tube_p_blkxfer. Models the Tube ULA (host byte
//   source, parasite write sink, NMI line) and a memory with configurable
//   ack latency, logs every bus cycle, and compares the logs against the
//   byte stream a block transfer should produce.
// -----------------------------------------------------------------------------
module tb_tube_p_blkxfer;

  localparam int NMI_HOLDOFF = 3;

  logic        p_phi2;
  logic        h_rst_b;
  logic        start;
  logic        abort;
  logic        dir;
  logic        two_byte;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] remaining;

  tube_p_blkxfer_if bus ();

  tube_p_blkxfer #(.NMI_HOLDOFF(NMI_HOLDOFF)) dut (
    .p_phi2    (p_phi2),
    .h_rst_b   (h_rst_b),
    .start     (start),
    .abort     (abort),
    .dir       (dir),
    .two_byte  (two_byte),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial p_phi2 = 1'b0;
  always #5 p_phi2 = ~p_phi2;

  // ---------------------------------------------------------------------------
  // Environment: host byte source, memory, NMI, ack generator
  // ---------------------------------------------------------------------------
  logic [7:0] host_arr [0:255];
  logic [7:0] mem_arr  [0:65535];
  int         nmi_mode;      // 0 = held low, 1 = random, 2 = held high
  int         ack_delay;
  int         wait_cnt;
  int         rd_count;
  logic       nmi_rand;
  logic       ack_noise;
  logic       log_clr;

  assign bus.t_rdata = host_arr[rd_count[7:0]];
  assign bus.m_rdata = mem_arr[bus.m_addr];
  assign bus.t_nmi_b = (nmi_mode == 0) ? 1'b0 : (nmi_mode == 1) ? nmi_rand : 1'b1;
  // Random ack pulses outside a request must be ignored by the engine.
  assign bus.m_ack   = bus.m_req ? (wait_cnt >= ack_delay) : ack_noise;

  // Bus logs
  int          cyc;
  int          cs_cyc_q [$];
  logic [7:0]  tw_q [$];
  logic [15:0] mw_addr_q [$];
  logic [7:0]  mw_data_q [$];
  logic [15:0] mr_addr_q [$];
  int          done_cnt;
  int          consec_cnt;
  int          req_cnt;
  logic        cs_prev;

  always @(posedge p_phi2) begin
    cyc       <= cyc + 1;
    nmi_rand  <= ($urandom_range(0, 2) == 0);
    ack_noise <= ($urandom_range(0, 3) == 0);
    if (bus.m_req && !bus.m_ack) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;

    if (log_clr) begin
      cs_cyc_q.delete();
      tw_q.delete();
      mw_addr_q.delete();
      mw_data_q.delete();
      mr_addr_q.delete();
      rd_count   <= 0;
      done_cnt   <= 0;
      consec_cnt <= 0;
      req_cnt    <= 0;
      cs_prev    <= 1'b1;
    end else begin
      cs_prev <= bus.t_cs_b;
      if (!bus.t_cs_b) begin
        cs_cyc_q.push_back(cyc);
        if (!cs_prev) consec_cnt <= consec_cnt + 1;
        if (bus.t_rdnw) rd_count <= rd_count + 1;
        else            tw_q.push_back(bus.t_wdata);
      end
      if (bus.m_req) req_cnt <= req_cnt + 1;
      if (bus.m_req && bus.m_ack) begin
        if (bus.m_we) begin
          mw_addr_q.push_back(bus.m_addr);
          mw_data_q.push_back(bus.m_wdata);
        end else begin
          mr_addr_q.push_back(bus.m_addr);
        end
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    @(posedge p_phi2);
    #1 log_clr = 1'b1;
    @(posedge p_phi2);
    #1 log_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge p_phi2);
    #1 start = 1'b1;
    @(posedge p_phi2);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int to;
    to = 0;
    while (done !== 1'b1 && to < 4000) begin
      @(negedge p_phi2);
      to++;
    end
    check({tag, "_timeout"}, (to < 4000), 1);
    @(posedge p_phi2);
    @(negedge p_phi2);
  endtask

  // One full transfer checked against the byte stream it should produce.
  task automatic run_xfer(input string name, input logic d, input logic tb2,
                          input logic [15:0] base, input int len,
                          input int nmode, input int adly);
    logic [7:0] exp_b [$];
    int bpn, bursts, nshort, nlong;
    nmi_mode  = nmode;
    ack_delay = adly;
    for (int i = 0; i < len; i++)
      exp_b.push_back(d ? mem_arr[16'(base + 16'(i))] : host_arr[i]);
    clear_logs();
    dir       = d;
    two_byte  = tb2;
    base_addr = base;
    length    = 16'(len);
    pulse_start();
    wait_done(name);

    $display("[TB] xfer %s dir=%0d two=%0d base=%04h len=%0d nmi=%0d ackdly=%0d",
             name, d, tb2, base, len, nmode, adly);

    check({name, "_done_cnt"},  done_cnt, 1);
    check({name, "_busy"},      busy, 0);
    check({name, "_t_own"},     bus.t_own, 0);
    check({name, "_remaining"}, remaining, 0);
    check({name, "_m_addr"},    bus.m_addr, 16'(base + 16'(len)));
    check({name, "_cs_consec"}, consec_cnt, 0);

    if (!d) begin
      check({name, "_tube_rd"}, rd_count, len);
      check({name, "_tube_wr"}, tw_q.size(), 0);
      check({name, "_mem_wr"},  mw_addr_q.size(), len);
      for (int i = 0; i < len && i < mw_addr_q.size(); i++) begin
        check({name, "_wr_addr"}, mw_addr_q[i], 16'(base + 16'(i)));
        check({name, "_wr_data"}, mw_data_q[i], exp_b[i]);
      end
    end else begin
      check({name, "_tube_rd"}, rd_count, 0);
      check({name, "_mem_rd"},  mr_addr_q.size(), len);
      check({name, "_tube_wr"}, tw_q.size(), len);
      for (int i = 0; i < len && i < mr_addr_q.size(); i++)
        check({name, "_rd_addr"}, mr_addr_q[i], 16'(base + 16'(i)));
      for (int i = 0; i < len && i < tw_q.size(); i++)
        check({name, "_tw_data"}, tw_q[i], exp_b[i]);
    end

    // With NMI held low and 0-wait memory: 3 cycles per byte inside a burst,
    // and each new burst waits out RECOVER, the holdoff and one ARM decision.
    if (nmode == 0 && adly == 0 && len > 0) begin
      bpn    = tb2 ? 2 : 1;
      bursts = (len + bpn - 1) / bpn;
      nshort = 0;
      nlong  = 0;
      for (int i = 1; i < cs_cyc_q.size(); i++) begin
        if (cs_cyc_q[i] - cs_cyc_q[i-1] == 3) nshort++;
        else if (cs_cyc_q[i] - cs_cyc_q[i-1] == NMI_HOLDOFF + 4) nlong++;
      end
      check({name, "_gap_burst"}, nshort, len - bursts);
      check({name, "_gap_nmi"},   nlong,  bursts - 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int to;
    logic        rd;
    logic        rtwo;
    logic [15:0] rbase;
    int          rlen;

    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    wait_cnt  = 0;
    rd_count  = 0;
    done_cnt  = 0;
    consec_cnt = 0;
    req_cnt   = 0;
    cs_prev   = 1'b1;
    nmi_rand  = 1'b1;
    ack_noise = 1'b0;
    log_clr   = 1'b0;
    nmi_mode  = 2;
    ack_delay = 0;
    h_rst_b   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    dir       = 1'b0;
    two_byte  = 1'b0;
    base_addr = 16'h0000;
    length    = 16'h0000;
    for (int i = 0; i < 256; i++) host_arr[i] = 8'(i);
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'h00;

    // Reset values
    #3;
    check("rst_cs_b",      bus.t_cs_b, 1);
    check("rst_t_addr",    bus.t_addr, 5);
    check("rst_t_rdnw",    bus.t_rdnw, 1);
    check("rst_t_own",     bus.t_own, 0);
    check("rst_m_req",     bus.m_req, 0);
    check("rst_busy",      busy, 0);
    check("rst_remaining", remaining, 0);
    repeat (3) @(negedge p_phi2);
    h_rst_b = 1'b1;

    // Reset in the middle of a memory write
    nmi_mode  = 0;
    ack_delay = 3;
    clear_logs();
    dir = 1'b0; two_byte = 1'b0; base_addr = 16'h1234; length = 16'd4;
    pulse_start();
    to = 0;
    while (!(bus.m_req && bus.m_we) && to < 200) begin
      @(negedge p_phi2);
      to++;
    end
    check("midrst_reach_memwr", (to < 200), 1);
    #2 h_rst_b = 1'b0;
    #1;
    $display("[TB] reset asserted during MEM_WR");
    check("midrst_cs_b",      bus.t_cs_b, 1);
    check("midrst_t_own",     bus.t_own, 0);
    check("midrst_m_req",     bus.m_req, 0);
    check("midrst_m_we",      bus.m_we, 0);
    check("midrst_m_addr",    bus.m_addr, 0);
    check("midrst_busy",      busy, 0);
    check("midrst_done",      done, 0);
    check("midrst_remaining", remaining, 0);
    @(negedge p_phi2);
    h_rst_b = 1'b1;
    repeat (2) @(negedge p_phi2);

    // Host-to-parasite, single byte per NMI
    host_arr[0] = 8'h11; host_arr[1] = 8'h22; host_arr[2] = 8'h33;
    run_xfer("h2p_1b", 1'b0, 1'b0, 16'h0400, 3, 0, 0);

    // Parasite-to-host, two bytes per NMI, address wraps FFFF -> 0000
    mem_arr[16'hFFFF] = 8'hAA; mem_arr[16'h0000] = 8'hBB;
    mem_arr[16'h0001] = 8'hCC; mem_arr[16'h0002] = 8'hDD;
    run_xfer("p2h_2b_wrap", 1'b1, 1'b1, 16'hFFFF, 4, 0, 0);

    // NMI held low continuously: second access must wait out the holdoff
    host_arr[0] = 8'h5A; host_arr[1] = 8'hA5;
    run_xfer("holdoff", 1'b0, 1'b0, 16'h3000, 2, 0, 0);

    // Zero-length start
    nmi_mode = 0;
    clear_logs();
    dir = 1'b0; two_byte = 1'b0; base_addr = 16'h0800; length = 16'd0;
    @(posedge p_phi2);
    #1 start = 1'b1;
    @(posedge p_phi2);
    #1 start = 1'b0;
    @(negedge p_phi2);
    check("len0_done_2nd", done, 1);
    @(negedge p_phi2);
    check("len0_done_pulse", done, 0);
    repeat (4) @(negedge p_phi2);
    $display("[TB] xfer len0");
    check("len0_cs",      cs_cyc_q.size(), 0);
    check("len0_req",     req_cnt, 0);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_busy",    busy, 0);

    // Abort during a slow memory write; a start while busy is ignored
    for (int i = 0; i < 8; i++) host_arr[i] = 8'(8'h60 + i);
    nmi_mode  = 0;
    ack_delay = 5;
    clear_logs();
    dir = 1'b0; two_byte = 1'b0; base_addr = 16'h2000; length = 16'd5;
    pulse_start();
    to = 0;
    while (!(bus.m_req && bus.m_we) && to < 200) begin
      @(negedge p_phi2);
      to++;
    end
    check("abort_reach_memwr", (to < 200), 1);
    abort = 1'b1;
    @(posedge p_phi2);
    #1 begin start = 1'b1; base_addr = 16'h5555; end
    @(posedge p_phi2);
    #1 start = 1'b0;
    wait_done("abort");
    abort = 1'b0;
    $display("[TB] xfer abort base=2000 len=5");
    check("abort_wr_cnt",    mw_addr_q.size(), 1);
    if (mw_addr_q.size() > 0) begin
      check("abort_wr_addr", mw_addr_q[0], 16'h2000);
      check("abort_wr_data", mw_data_q[0], 8'h60);
    end
    check("abort_remaining", remaining, 16'd5 - 16'(mw_addr_q.size()));
    check("abort_done_cnt",  done_cnt, 1);
    repeat (5) @(negedge p_phi2);
    check("abort_no_restart", busy, 0);
    check("abort_cs_consec",  consec_cnt, 0);

    // Randomised transfers
    for (int n = 0; n < 12; n++) begin
      rd    = 1'($urandom_range(0, 1));
      rtwo  = 1'($urandom_range(0, 1));
      rbase = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                          : 16'($urandom);
      rlen  = $urandom_range(1, 7);
      for (int i = 0; i < 16; i++) host_arr[i] = 8'($urandom);
      for (int i = 0; i < rlen; i++) mem_arr[16'(rbase + 16'(i))] = 8'($urandom);
      run_xfer($sformatf("rnd%0d", n), rd, rtwo, rbase, rlen,
               $urandom_range(0, 1), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
